fwd_scoreboard: RTL

//  Parametrised successor to the combinational operand bypass: tracks in-flight destination registers in an

---
 rtl/fwd_scoreboard_pkg.sv | 34 +++
 rtl/fwd_port_select.sv | 56 +++++
 rtl/fwd_scoreboard.sv | 104 ++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// ============================================================================
// Module : fwd_scoreboard_pkg
// Brief  : Shared defaults, shadow-pipeline entry type and constants.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fwd_scoreboard_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int NUM_RP_DEF = 2;
    localparam int DEPTH_DEF  = 3;
    localparam int LAT_W_DEF  = 2;

    // Entry fields are sized for the widest supported configuration;
    // narrower instances zero-extend into them.
    localparam int REG_AW_MAX = 8;
    localparam int LAT_W_MAX  = 4;

    typedef logic [REG_AW_MAX-1:0] reg_addr_t;
    typedef logic [LAT_W_MAX-1:0]  lat_t;

    typedef struct packed {
        logic      vld;
        reg_addr_t rd;
        lat_t      lat;
    } entry_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

`default_nettype wire

// File: rtl/fwd_port_select.sv
// ============================================================================
// Module : fwd_port_select
// Brief  : Per-read-port youngest-producer match, returns bypass data/hit/block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import fwd_scoreboard_pkg::*;

module fwd_port_select #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3
) (
    input  logic [REG_AW-1:0]           i_addr,
    input  logic                        i_used,
    input  logic [XLEN-1:0]             i_rf_data,
    input  logic [DEPTH*XLEN-1:0]       i_stage_result,
    input  logic [DEPTH-1:0]            i_vld,
    input  logic [DEPTH-1:0]            i_flush_mask,
    input  logic [DEPTH*REG_AW_MAX-1:0] i_rd,
    input  logic [DEPTH*LAT_W_MAX-1:0]  i_lat,
    output logic [XLEN-1:0]             o_data,
    output logic                        o_hit,
    output logic                        o_block
);

    logic [REG_AW_MAX-1:0] w_addr;

    assign w_addr = REG_AW_MAX'(i_addr);

    // Scan oldest to youngest so a younger match fully overrides an older one;
    // a not-ready youngest producer therefore never leaks an older value.
    always_comb begin
        o_data  = i_rf_data;
        o_hit   = 1'b0;
        o_block = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_used && (w_addr != ZERO_REG) && i_vld[k] && !i_flush_mask[k] &&
                (i_rd[k*REG_AW_MAX +: REG_AW_MAX] == w_addr)) begin
                if (int'(i_lat[k*LAT_W_MAX +: LAT_W_MAX]) <= k) begin
                    o_data  = i_stage_result[k*XLEN +: XLEN];
                    o_hit   = 1'b1;
                    o_block = 1'b0;
                end else begin
                    o_data  = i_rf_data;
                    o_hit   = 1'b0;
                    o_block = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fwd_scoreboard.sv
// ============================================================================
// Module : fwd_scoreboard
// Brief  : Shadow pipeline of in-flight destinations with operand bypass/stall.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

import fwd_scoreboard_pkg::*;

module fwd_scoreboard #(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int NUM_RP = NUM_RP_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LAT_W  = LAT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_issue_valid,
    input  logic [REG_AW-1:0]        i_issue_rd,
    input  logic [LAT_W-1:0]         i_issue_lat,
    input  logic [NUM_RP*REG_AW-1:0] i_rp_addr,
    input  logic [NUM_RP-1:0]        i_rp_used,
    input  logic [NUM_RP*XLEN-1:0]   i_rf_data,
    input  logic [DEPTH*XLEN-1:0]    i_stage_result,
    input  logic [DEPTH-1:0]         i_flush_mask,
    input  logic                     i_flush_issue,
    output logic [NUM_RP*XLEN-1:0]   o_fwd_data,
    output logic [NUM_RP-1:0]        o_fwd_hit,
    output logic                     o_stall,
    output logic [31:0]              o_stall_cnt
);

    entry_t                      r_entry [DEPTH];
    logic [31:0]                 r_stall_cnt;

    logic [DEPTH-1:0]            w_vld;
    logic [DEPTH*REG_AW_MAX-1:0] w_rd;
    logic [DEPTH*LAT_W_MAX-1:0]  w_lat;
    logic [NUM_RP-1:0]           w_block;
    logic                        w_stall;
    logic                        w_insert;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_flat
            assign w_vld[k]                              = r_entry[k].vld;
            assign w_rd[k*REG_AW_MAX +: REG_AW_MAX]      = r_entry[k].rd;
            assign w_lat[k*LAT_W_MAX +: LAT_W_MAX]       = r_entry[k].lat;
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_RP; i++) begin : g_port
            fwd_port_select #(
                .XLEN   (XLEN),
                .REG_AW (REG_AW),
                .DEPTH  (DEPTH)
            ) u_sel (
                .i_addr         (i_rp_addr[i*REG_AW +: REG_AW]),
                .i_used         (i_rp_used[i]),
                .i_rf_data      (i_rf_data[i*XLEN +: XLEN]),
                .i_stage_result (i_stage_result),
                .i_vld          (w_vld),
                .i_flush_mask   (i_flush_mask),
                .i_rd           (w_rd),
                .i_lat          (w_lat),
                .o_data         (o_fwd_data[i*XLEN +: XLEN]),
                .o_hit          (o_fwd_hit[i]),
                .o_block        (w_block[i])
            );
        end
    endgenerate

    // A killed ALU-stage instruction neither stalls nor enters the pipeline.
    assign w_stall  = (|w_block) && !i_flush_issue;
    assign w_insert = i_issue_valid && (i_issue_rd != '0) && !w_stall && !i_flush_issue;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_entry[k] <= '0;
            end
            r_stall_cnt <= '0;
        end else begin
            r_entry[0] <= '{vld: w_insert,
                            rd:  REG_AW_MAX'(i_issue_rd),
                            lat: LAT_W_MAX'(i_issue_lat)};
            for (int k = 1; k < DEPTH; k++) begin
                r_entry[k] <= '{vld: r_entry[k-1].vld && !i_flush_mask[k-1],
                                rd:  r_entry[k-1].rd,
                                lat: r_entry[k-1].lat};
            end
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_stall     = w_stall;
    assign o_stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire
